// File: rtl/csr_trap_ctrl_pkg.sv
// csr_trap_ctrl_pkg: shared XLEN, machine-mode CSR addresses, trap sequencer states and mstatus field helpers
package csr_trap_ctrl_pkg;
  localparam int XLEN = 32;
  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MTVAL    = 12'h343;
  localparam int MSTATUS_MIE     = 3;
  localparam int MSTATUS_MPIE    = 7;
  localparam int MSTATUS_MPP_LSB = 11;
  typedef enum logic [2:0] {
    IDLE,
    WR_MEPC,
    WR_MCAUSE,
    WR_MTVAL,
    WR_MSTATUS,
    JUMP,
    MRET_MSTATUS,
    MRET_JUMP
  } state_e;
  function automatic logic [XLEN-1:0] mstatus_on_trap(input logic [XLEN-1:0] m);
    logic [XLEN-1:0] r;
    r = m;
    r[MSTATUS_MPIE] = m[MSTATUS_MIE];
    r[MSTATUS_MIE] = 1'b0;
    r[MSTATUS_MPP_LSB +: 2] = 2'b11;
    return r;
  endfunction
  function automatic logic [XLEN-1:0] mstatus_on_mret(input logic [XLEN-1:0] m);
    logic [XLEN-1:0] r;
    r = m;
    r[MSTATUS_MIE] = m[MSTATUS_MPIE];
    r[MSTATUS_MPIE] = 1'b1;
    r[MSTATUS_MPP_LSB +: 2] = 2'b11;
    return r;
  endfunction
endpackage

// File: rtl/csr_trap_ctrl.sv
// csr_trap_ctrl: sole owner of the M-mode CSR file ports; arbitrates execute-stage CSR access against trap-entry and MRET sequences
// Ports: clk/reset_n (async active-low); csr_req_v_i/csr_we_i/csr_adr_i/csr_wdata_i -> csr_gnt_o/csr_rdata_o (execute side);
//        trap_v_i/trap_cause_i/trap_pc_i/trap_tval_i, mret_v_i (sequence requests); busy_o, redirect_v_o/redirect_pc_o (fetch side);
//        csr_write_v_o/csr_adr_write_o/csr_wdata_o/csr_adr_read_o -> CSR file, csr_rdata_i <- CSR file (combinational read).
// Build option: CSR_TRAP_VECTORED_EN enables vectored interrupt targets when mtvec.MODE==1.
module csr_trap_ctrl
  import csr_trap_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            reset_n,
  input  logic            csr_req_v_i,
  input  logic            csr_we_i,
  input  logic [11:0]     csr_adr_i,
  input  logic [XLEN-1:0] csr_wdata_i,
  output logic            csr_gnt_o,
  output logic [XLEN-1:0] csr_rdata_o,
  input  logic            trap_v_i,
  input  logic [XLEN-1:0] trap_cause_i,
  input  logic [XLEN-1:0] trap_pc_i,
  input  logic [XLEN-1:0] trap_tval_i,
  input  logic            mret_v_i,
  output logic            busy_o,
  output logic            redirect_v_o,
  output logic [XLEN-1:0] redirect_pc_o,
  output logic            csr_write_v_o,
  output logic [11:0]     csr_adr_write_o,
  output logic [XLEN-1:0] csr_wdata_o,
  output logic [11:0]     csr_adr_read_o,
  input  logic [XLEN-1:0] csr_rdata_i
);
  state_e state_q, state_d;
  logic [XLEN-1:0] cause_q, cause_d, pc_q, pc_d, tval_q, tval_d;
  logic busy_q, busy_d;
  logic gnt, we;
  logic [XLEN-1:0] vec_base, trap_target;
  assign vec_base = {csr_rdata_i[XLEN-1:2], 2'b00};
`ifdef CSR_TRAP_VECTORED_EN
  assign trap_target = (csr_rdata_i[1:0] == 2'b01 && cause_q[XLEN-1]) ? vec_base + {cause_q[XLEN-3:0], 2'b00} : vec_base;
`else
  assign trap_target = vec_base;
`endif
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    pc_d = pc_q;
    tval_d = tval_q;
    gnt = 1'b0;
    we = 1'b0;
    csr_adr_write_o = '0;
    csr_wdata_o = '0;
    csr_adr_read_o = '0;
    csr_rdata_o = '0;
    redirect_v_o = 1'b0;
    redirect_pc_o = '0;
    case (state_q)
      IDLE: begin
        if (trap_v_i) begin
          cause_d = trap_cause_i;
          pc_d = trap_pc_i;
          tval_d = trap_tval_i;
          state_d = WR_MEPC;
        end else if (mret_v_i) begin
          state_d = MRET_MSTATUS;
        end else if (csr_req_v_i) begin
          gnt = 1'b1;
          we = csr_we_i;
          csr_adr_read_o = csr_adr_i;
          csr_rdata_o = csr_rdata_i;
          csr_adr_write_o = csr_adr_i;
          csr_wdata_o = csr_wdata_i;
        end
      end
      WR_MEPC: begin
        we = 1'b1;
        csr_adr_write_o = CSR_MEPC;
        csr_wdata_o = {pc_q[XLEN-1:2], 2'b00};
        state_d = WR_MCAUSE;
      end
      WR_MCAUSE: begin
        we = 1'b1;
        csr_adr_write_o = CSR_MCAUSE;
        csr_wdata_o = cause_q;
        state_d = WR_MTVAL;
      end
      WR_MTVAL: begin
        we = 1'b1;
        csr_adr_write_o = CSR_MTVAL;
        csr_wdata_o = tval_q;
        state_d = WR_MSTATUS;
      end
      WR_MSTATUS: begin
        we = 1'b1;
        csr_adr_read_o = CSR_MSTATUS;
        csr_adr_write_o = CSR_MSTATUS;
        csr_wdata_o = mstatus_on_trap(csr_rdata_i);
        state_d = JUMP;
      end
      JUMP: begin
        csr_adr_read_o = CSR_MTVEC;
        redirect_v_o = 1'b1;
        redirect_pc_o = trap_target;
        state_d = IDLE;
      end
      MRET_MSTATUS: begin
        we = 1'b1;
        csr_adr_read_o = CSR_MSTATUS;
        csr_adr_write_o = CSR_MSTATUS;
        csr_wdata_o = mstatus_on_mret(csr_rdata_i);
        state_d = MRET_JUMP;
      end
      MRET_JUMP: begin
        csr_adr_read_o = CSR_MEPC;
        redirect_v_o = 1'b1;
        redirect_pc_o = vec_base;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
  end
  // gnt/write are gated by reset_n so nothing reaches the CSR file while reset is asserted
  assign csr_gnt_o = gnt & reset_n;
  assign csr_write_v_o = we & reset_n;
  assign busy_o = busy_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      busy_q <= 1'b0;
      cause_q <= '0;
      pc_q <= '0;
      tval_q <= '0;
    end else begin
      state_q <= state_d;
      busy_q <= busy_d;
      cause_q <= cause_d;
      pc_q <= pc_d;
      tval_q <= tval_d;
    end
  end
endmodule

// File: tb/tb_csr_trap_ctrl.sv
// tb_csr_trap_ctrl: randomized self-checking bench for csr_trap_ctrl against a transaction-level model
module tb_csr_trap_ctrl;
  import csr_trap_ctrl_pkg::*;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic clr = 1'b1;
  logic csr_req_v_i = 1'b0, csr_we_i = 1'b0, trap_v_i = 1'b0, mret_v_i = 1'b0;
  logic [11:0] csr_adr_i = '0;
  logic [31:0] csr_wdata_i = '0, trap_cause_i = '0, trap_pc_i = '0, trap_tval_i = '0;
  logic csr_gnt_o, busy_o, redirect_v_o, csr_write_v_o;
  logic [31:0] csr_rdata_o, redirect_pc_o, csr_wdata_o, csr_rdata_i;
  logic [11:0] csr_adr_write_o, csr_adr_read_o;
  int n_cmp = 0, n_err = 0;
  logic [31:0] csr_mem [0:4095];
  logic [31:0] ref_mem [0:4095];
  logic [11:0] adrs [6] = '{CSR_MSTATUS, CSR_MTVEC, CSR_MSCRATCH, CSR_MEPC, CSR_MCAUSE, CSR_MTVAL};
  typedef struct {
    logic        we;
    logic [11:0] wadr;
    logic [31:0] wdata;
    logic [11:0] radr;
    logic        redir;
    logic [31:0] rpc;
  } exp_t;
  exp_t q[$];

  csr_trap_ctrl dut (
    .clk(clk), .reset_n(reset_n),
    .csr_req_v_i(csr_req_v_i), .csr_we_i(csr_we_i), .csr_adr_i(csr_adr_i), .csr_wdata_i(csr_wdata_i),
    .csr_gnt_o(csr_gnt_o), .csr_rdata_o(csr_rdata_o),
    .trap_v_i(trap_v_i), .trap_cause_i(trap_cause_i), .trap_pc_i(trap_pc_i), .trap_tval_i(trap_tval_i),
    .mret_v_i(mret_v_i), .busy_o(busy_o), .redirect_v_o(redirect_v_o), .redirect_pc_o(redirect_pc_o),
    .csr_write_v_o(csr_write_v_o), .csr_adr_write_o(csr_adr_write_o), .csr_wdata_o(csr_wdata_o),
    .csr_adr_read_o(csr_adr_read_o), .csr_rdata_i(csr_rdata_i)
  );

  always #5 clk = ~clk;

  // CSR file stand-in: combinational read, write at the clock edge
  assign csr_rdata_i = csr_mem[csr_adr_read_o];
  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 4096; i++) csr_mem[i] <= '0;
    end else if (csr_write_v_o) begin
      csr_mem[csr_adr_write_o] <= csr_wdata_o;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] trap_ms(input logic [31:0] m);
    return (m & ~32'h1888) | 32'h1800 | (m[3] ? 32'h80 : 32'h0);
  endfunction
  function automatic logic [31:0] mret_ms(input logic [31:0] m);
    return (m & ~32'h88) | 32'h1880 | (m[7] ? 32'h8 : 32'h0);
  endfunction
  function automatic logic [31:0] trap_vec(input logic [31:0] tv, input logic [31:0] cause);
`ifdef CSR_TRAP_VECTORED_EN
    if (tv[1:0] == 2'b01 && cause[31]) return (tv & ~32'h3) + (cause << 2);
`endif
    return tv & ~32'h3;
  endfunction

  // Model: an accepted trap/MRET expands into its list of per-cycle effects; otherwise IDLE pass-through.
  always @(negedge clk) begin
    exp_t e;
    if (clr) begin
      for (int i = 0; i < 4096; i++) ref_mem[i] <= '0;
      q.delete();
    end else if (!reset_n) begin
      q.delete();
      chk("rst_gnt", {31'b0, csr_gnt_o}, 32'h0);
      chk("rst_we", {31'b0, csr_write_v_o}, 32'h0);
      chk("rst_busy", {31'b0, busy_o}, 32'h0);
      chk("rst_redir", {31'b0, redirect_v_o}, 32'h0);
    end else if (q.size() > 0) begin
      e = q.pop_front();
      chk("seq_busy", {31'b0, busy_o}, 32'h1);
      chk("seq_gnt", {31'b0, csr_gnt_o}, 32'h0);
      chk("seq_rdata", csr_rdata_o, 32'h0);
      chk("seq_we", {31'b0, csr_write_v_o}, {31'b0, e.we});
      chk("seq_radr", {20'b0, csr_adr_read_o}, {20'b0, e.radr});
      chk("seq_redir", {31'b0, redirect_v_o}, {31'b0, e.redir});
      if (e.we) begin
        chk("seq_wadr", {20'b0, csr_adr_write_o}, {20'b0, e.wadr});
        chk("seq_wdata", csr_wdata_o, e.wdata);
        ref_mem[e.wadr] <= e.wdata;
      end
      if (e.redir) chk("seq_rpc", redirect_pc_o, e.rpc);
    end else begin
      chk("idle_busy", {31'b0, busy_o}, 32'h0);
      chk("idle_redir", {31'b0, redirect_v_o}, 32'h0);
      if (trap_v_i) begin
        q.push_back('{1'b1, CSR_MEPC, trap_pc_i & ~32'h3, 12'h0, 1'b0, 32'h0});
        q.push_back('{1'b1, CSR_MCAUSE, trap_cause_i, 12'h0, 1'b0, 32'h0});
        q.push_back('{1'b1, CSR_MTVAL, trap_tval_i, 12'h0, 1'b0, 32'h0});
        q.push_back('{1'b1, CSR_MSTATUS, trap_ms(ref_mem[CSR_MSTATUS]), CSR_MSTATUS, 1'b0, 32'h0});
        q.push_back('{1'b0, 12'h0, 32'h0, CSR_MTVEC, 1'b1, trap_vec(ref_mem[CSR_MTVEC], trap_cause_i)});
      end else if (mret_v_i) begin
        q.push_back('{1'b1, CSR_MSTATUS, mret_ms(ref_mem[CSR_MSTATUS]), CSR_MSTATUS, 1'b0, 32'h0});
        q.push_back('{1'b0, 12'h0, 32'h0, CSR_MEPC, 1'b1, ref_mem[CSR_MEPC] & ~32'h3});
      end
      if (!trap_v_i && !mret_v_i && csr_req_v_i) begin
        chk("pt_gnt", {31'b0, csr_gnt_o}, 32'h1);
        chk("pt_radr", {20'b0, csr_adr_read_o}, {20'b0, csr_adr_i});
        chk("pt_rdata", csr_rdata_o, ref_mem[csr_adr_i]);
        chk("pt_we", {31'b0, csr_write_v_o}, {31'b0, csr_we_i});
        if (csr_we_i) begin
          chk("pt_wadr", {20'b0, csr_adr_write_o}, {20'b0, csr_adr_i});
          chk("pt_wdata", csr_wdata_o, csr_wdata_i);
          ref_mem[csr_adr_i] <= csr_wdata_i;
        end
      end else begin
        chk("idle_gnt", {31'b0, csr_gnt_o}, 32'h0);
        chk("idle_we", {31'b0, csr_write_v_o}, 32'h0);
        chk("idle_radr", {20'b0, csr_adr_read_o}, 32'h0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic csr_wr(input logic [11:0] a, input logic [31:0] d);
    csr_req_v_i = 1'b1;
    csr_we_i = 1'b1;
    csr_adr_i = a;
    csr_wdata_i = d;
    tick();
    csr_req_v_i = 1'b0;
    csr_we_i = 1'b0;
  endtask
  task automatic start_trap(input logic [31:0] c, input logic [31:0] p, input logic [31:0] t);
    trap_v_i = 1'b1;
    trap_cause_i = c;
    trap_pc_i = p;
    trap_tval_i = t;
  endtask
  // From cycle 0 of an accepted trap: busy in cycles 1-5, redirect to tgt in cycle 5, idle in cycle 6
  task automatic run_trap(input string nm, input logic [31:0] tgt);
    tick();
    trap_v_i = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      #1;
      chk({nm, "_busy"}, {31'b0, busy_o}, 32'h1);
      if (k == 5) begin
        chk({nm, "_redir_v"}, {31'b0, redirect_v_o}, 32'h1);
        chk({nm, "_redir_pc"}, redirect_pc_o, tgt);
      end
      tick();
    end
    #1;
    chk({nm, "_busy_end"}, {31'b0, busy_o}, 32'h0);
  endtask

  initial begin
    csr_req_v_i = 1'b1;
    csr_we_i = 1'b1;
    csr_adr_i = CSR_MSCRATCH;
    csr_wdata_i = 32'h1234;
    tick();
    tick();
    chk("reset_gnt", {31'b0, csr_gnt_o}, 32'h0);
    chk("reset_we", {31'b0, csr_write_v_o}, 32'h0);
    chk("reset_busy", {31'b0, busy_o}, 32'h0);
    chk("reset_redir", {31'b0, redirect_v_o}, 32'h0);
    clr = 1'b0;
    csr_req_v_i = 1'b0;
    csr_we_i = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    // pass-through write then read-back
    csr_req_v_i = 1'b1;
    csr_we_i = 1'b1;
    csr_adr_i = 12'h340;
    csr_wdata_i = 32'hDEADBEEF;
    #1;
    chk("pt_wr_gnt", {31'b0, csr_gnt_o}, 32'h1);
    chk("pt_wr_rdata", csr_rdata_o, 32'h0);
    tick();
    csr_we_i = 1'b0;
    #1;
    chk("pt_rd_rdata", csr_rdata_o, 32'hDEADBEEF);
    tick();
    csr_req_v_i = 1'b0;
    // trap entry
    csr_wr(CSR_MTVEC, 32'h100);
    csr_wr(CSR_MSTATUS, 32'h8);
    start_trap(32'h2, 32'h2002, 32'h13);
    run_trap("trap", 32'h100);
    chk("trap_mepc", csr_mem[CSR_MEPC], 32'h2000);
    chk("trap_mcause", csr_mem[CSR_MCAUSE], 32'h2);
    chk("trap_mtval", csr_mem[CSR_MTVAL], 32'h13);
    chk("trap_mstatus", csr_mem[CSR_MSTATUS], 32'h1880);
    tick();
    // MRET
    csr_wr(CSR_MEPC, 32'h2004);
    mret_v_i = 1'b1;
    tick();
    mret_v_i = 1'b0;
    #1;
    chk("mret_busy1", {31'b0, busy_o}, 32'h1);
    tick();
    #1;
    chk("mret_redir_v", {31'b0, redirect_v_o}, 32'h1);
    chk("mret_redir_pc", redirect_pc_o, 32'h2004);
    tick();
    #1;
    chk("mret_busy_end", {31'b0, busy_o}, 32'h0);
    chk("mret_mstatus", csr_mem[CSR_MSTATUS], 32'h1888);
    tick();
    // collision: trap + mret + CSR write together, then CSR request while busy
    start_trap(32'h5, 32'h3000, 32'h0);
    mret_v_i = 1'b1;
    csr_req_v_i = 1'b1;
    csr_we_i = 1'b1;
    csr_adr_i = CSR_MSCRATCH;
    csr_wdata_i = 32'h55;
    #1;
    chk("coll_gnt", {31'b0, csr_gnt_o}, 32'h0);
    chk("coll_we", {31'b0, csr_write_v_o}, 32'h0);
    tick();
    trap_v_i = 1'b0;
    mret_v_i = 1'b0;
    #1;
    chk("busy_gnt", {31'b0, csr_gnt_o}, 32'h0);
    repeat (5) tick();
    csr_req_v_i = 1'b0;
    csr_we_i = 1'b0;
    chk("coll_mscratch", csr_mem[CSR_MSCRATCH], 32'hDEADBEEF);
    chk("coll_mcause", csr_mem[CSR_MCAUSE], 32'h5);
    tick();
    // reset while in WR_MCAUSE, then a fresh trap
    start_trap(32'h9, 32'h4000, 32'h77);
    tick();
    trap_v_i = 1'b0;
    tick();
    reset_n = 1'b0;
    #1;
    chk("midrst_busy", {31'b0, busy_o}, 32'h0);
    chk("midrst_we", {31'b0, csr_write_v_o}, 32'h0);
    chk("midrst_redir", {31'b0, redirect_v_o}, 32'h0);
    tick();
    reset_n = 1'b1;
    tick();
    chk("midrst_mcause_kept", csr_mem[CSR_MCAUSE], 32'h5);
    start_trap(32'hB, 32'h5008, 32'h1);
    run_trap("post_rst", 32'h100);
    chk("post_rst_mcause", csr_mem[CSR_MCAUSE], 32'hB);
    tick();
    // vectored interrupt target
    csr_wr(CSR_MTVEC, 32'h101);
    start_trap(32'h80000007, 32'h6000, 32'h0);
`ifdef CSR_TRAP_VECTORED_EN
    run_trap("vec", 32'h11C);
`else
    run_trap("vec", 32'h100);
`endif
    tick();
    // randomized traffic
    repeat (3000) begin
      reset_n = $urandom_range(0, 299) != 0;
      trap_v_i = $urandom_range(0, 15) == 0;
      mret_v_i = $urandom_range(0, 15) == 0;
      csr_req_v_i = $urandom_range(0, 1) == 1;
      csr_we_i = $urandom_range(0, 1) == 1;
      csr_adr_i = adrs[$urandom_range(0, 5)];
      csr_wdata_i = $urandom;
      trap_cause_i = $urandom_range(0, 1) == 1 ? (32'h80000000 | 32'($urandom_range(0, 31))) : $urandom;
      trap_pc_i = $urandom;
      trap_tval_i = $urandom;
      tick();
    end
    reset_n = 1'b1;
    trap_v_i = 1'b0;
    mret_v_i = 1'b0;
    csr_req_v_i = 1'b0;
    repeat (8) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/csr_trap_ctrl.md
# csr_trap_ctrl

Sequencer and single owner of the machine-mode CSR file's write and read ports. It arbitrates CSR-instruction accesses from the execute stage against multi-cycle trap-entry and MRET sequences. During trap entry it updates mepc, mcause, mtval and mstatus; on MRET it restores mstatus. Both sequences end with a one-cycle redirect to the fetch unit. It sits between the execute stage and the CSR file, and both are instantiated side by side in the core top.

## Interface
- XLEN, 32, data width, taken from the shared package (not a module parameter)
- clk  in  1  core clock
- reset_n  in  1  asynchronous, active-low reset
- csr_req_v_i  in  1  execute-stage CSR access request
- csr_we_i  in  1  request writes (else read-only)
- csr_adr_i  in  12  CSR address of request
- csr_wdata_i  in  XLEN  write data (already merged for set/clear by execute)
- csr_gnt_o  out  1  request accepted this cycle
- csr_rdata_o  out  XLEN  old CSR value, valid when csr_gnt_o
- trap_v_i  in  1  trap request (exception or interrupt)
- trap_cause_i  in  XLEN  mcause value; bit XLEN-1 = interrupt
- trap_pc_i  in  XLEN  PC of trapping instruction
- trap_tval_i  in  XLEN  mtval value
- mret_v_i  in  1  MRET request
- busy_o  out  1  sequence in progress
- redirect_v_o  out  1  one-cycle fetch redirect
- redirect_pc_o  out  XLEN  redirect target
- csr_write_v_o  out  1  to CSR file write enable
- csr_adr_write_o  out  12  to CSR file write address
- csr_wdata_o  out  XLEN  to CSR file write data
- csr_adr_read_o  out  12  to CSR file read address
- csr_rdata_i  in  XLEN  from CSR file, combinational read data

## Operation
- Priority in IDLE: trap_v_i > mret_v_i > csr_req_v_i. The loser is dropped, and upstream re-presents it after busy_o falls.
- CSR pass-through is active only in IDLE with no trap or MRET: csr_gnt_o=csr_req_v_i, csr_adr_read_o=csr_adr_i, csr_rdata_o=csr_rdata_i, csr_write_v_o=csr_req_v_i&csr_we_i, address and data taken from the request. Read returns the pre-write value; the write lands at the next edge.
- Trap accept captures cause, pc and tval into registers and moves to WR_MEPC.
- Trap state path: WR_MEPC (write trap_pc & ~3) -> WR_MCAUSE -> WR_MTVAL -> WR_MSTATUS -> JUMP -> IDLE.
- WR_MSTATUS reads mstatus and writes it back with MPIE(bit7)=MIE(bit3), MIE=0, MPP(12:11)=2'b11.
- MRET state path: MRET_MSTATUS -> MRET_JUMP -> IDLE.
- MRET_MSTATUS reads mstatus and writes it back with MIE=MPIE, MPIE=1, MPP=2'b11.
- JUMP: csr_adr_read_o=CSR_MTVEC, redirect_v_o=1, redirect_pc_o={mtvec[XLEN-1:2],2'b00}.
- MRET_JUMP: csr_adr_read_o=CSR_MEPC, redirect_v_o=1, redirect_pc_o={mepc[XLEN-1:2],2'b00}.
- Outside IDLE: csr_gnt_o=0, and csr_rdata_o=0.
- trap_v_i and mret_v_i are ignored whenever busy_o=1.
- When no read is needed, csr_adr_read_o=0.

## Timing
- Trap accepted at cycle 0: writes at the ends of cycles 1–4; redirect_v_o high in cycle 5; IDLE in cycle 6, where a new request can be accepted.
- MRET accepted at cycle 0: mstatus written at the end of cycle 1; redirect in cycle 2; IDLE in cycle 3.
- busy_o = (state != IDLE), registered, and rises the cycle after accept.
- Reset: state=IDLE. busy_o, redirect_v_o, csr_gnt_o and csr_write_v_o are 0 and the captured registers are 0; gnt and write are forced low while reset_n is low.
- Reset mid-sequence aborts immediately with no further writes. Writes already committed are the CSR file's concern, since it is reset too.

## Configuration
- CSR_TRAP_VECTORED_EN defined: in JUMP, if mtvec[1:0]==2'b01 and cause[XLEN-1]=1, redirect_pc_o = base + (cause[XLEN-2:0] << 2). Otherwise the base is used.
- CSR_TRAP_VECTORED_EN undefined: mtvec[1:0] is ignored and redirect_pc_o is always the base.

## Structure
- Shared package holds XLEN, the CSR_* address constants, an enum type for the state machine, and the bit indices MSTATUS_MIE=3, MSTATUS_MPIE=7, MSTATUS_MPP_LSB=11.
- Single module with no sub-module; the CSR file is instantiated beside it in the core top.

## Test plan
- Pass-through: CSR write with mscratch=0x0, adr=0x340, wdata=0xDEADBEEF -> gnt=1, rdata=0x0. A following read returns 0xDEADBEEF.
- Trap entry: mtvec=0x100, mstatus=0x8 (MIE set), trap with cause=2, pc=0x2002, tval=0x13. Required:
  - mepc=0x2000, mcause=2, mtval=0x13, mstatus=0x1880;
  - redirect 0x100 in cycle 5;
  - busy_o high in cycles 1–5.
- MRET: mstatus=0x1880, mepc=0x2004 -> mstatus=0x1888, redirect 0x2004 in cycle 2.
- Collisions:
  - trap, MRET and CSR write together in IDLE -> only the trap sequence runs, gnt=0, no CSR-instruction write;
  - CSR request during busy -> gnt=0.
- Reset mid-sequence: reset_n low in WR_MCAUSE -> outputs 0 and state IDLE; after release, a new trap completes normally.
- Vectored (macro on): mtvec=0x101, cause=0x80000007 -> redirect 0x11C. With the macro off, the same stimulus redirects to 0x100.
